// File: rtl/merge_pkg.sv
// Shared types and helpers for the merge-sort tree nodes.
package merge_pkg;

    typedef enum logic [1:0] {
        MERGE   = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } state_t;

    function automatic int unsigned run_len(input int unsigned log2_run);
        return 32'(1) << log2_run;
    endfunction

endpackage

// File: rtl/merge_cmp.sv
// Head comparator: selects side A when a <= b, so ties keep the merge stable.
module merge_cmp #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  take_a_c
);

    assign take_a_c = (a <= b);

endmodule

// File: rtl/merge_node2.sv
// Two-way merge node: combines two sorted RUN_LEN runs from upstream FIFOs
// into one sorted 2*RUN_LEN run, popping the smaller head each cycle.
module merge_node2
    import merge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOG2_RUN   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a_dcmp,
    input  logic                  a_empty,
    output logic                  a_rd_en,
    input  logic [DATA_WIDTH-1:0] b_dcmp,
    input  logic                  b_empty,
    output logic                  b_rd_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_wr_en,
    output logic                  out_last
);

    localparam int unsigned RUN_LEN = run_len(LOG2_RUN);
    localparam int unsigned CNT_W   = LOG2_RUN + 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(RUN_LEN);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt_a;
    logic [CNT_W-1:0]        cnt_b;
    logic [CNT_W-1:0]        cnt_a_nxt;
    logic [CNT_W-1:0]        cnt_b_nxt;
    logic                    take_a_c;
    logic                    pop_a;
    logic                    pop_b;
    logic                    run_end;
    logic [DATA_WIDTH-1:0]   pop_data;

    merge_cmp #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cmp (
        .a        (a_dcmp),
        .b        (b_dcmp),
        .take_a_c (take_a_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MERGE;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            state <= state_nxt;
            cnt_a <= cnt_a_nxt;
            cnt_b <= cnt_b_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_a_nxt = cnt_a;
        cnt_b_nxt = cnt_b;
        pop_a     = 1'b0;
        pop_b     = 1'b0;
        run_end   = 1'b0;

        case (state)
            MERGE: begin
                // Both heads must be present before the compare is meaningful.
                if (!a_empty && !b_empty && !out_full) begin
                    if (take_a_c) pop_a = 1'b1;
                    else          pop_b = 1'b1;
                end
            end
            DRAIN_A: if (!a_empty && !out_full) pop_a = 1'b1;
            DRAIN_B: if (!b_empty && !out_full) pop_b = 1'b1;
            default: state_nxt = MERGE;
        endcase

        if (pop_a) cnt_a_nxt = cnt_a + CNT_W'(1);
        if (pop_b) cnt_b_nxt = cnt_b + CNT_W'(1);

        if (cnt_a_nxt == CNT_DONE && cnt_b_nxt == CNT_DONE) begin
            run_end   = 1'b1;
            cnt_a_nxt = '0;
            cnt_b_nxt = '0;
            state_nxt = MERGE;
        end else if (cnt_a_nxt == CNT_DONE) begin
            state_nxt = DRAIN_B;
        end else if (cnt_b_nxt == CNT_DONE) begin
            state_nxt = DRAIN_A;
        end
    end

    assign a_rd_en  = pop_a;
    assign b_rd_en  = pop_b;
    assign pop_data = pop_a ? a_dcmp : b_dcmp;

    // Output register: data holds across stalls, strobes are single-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_wr_en <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_wr_en <= pop_a | pop_b;
            out_last  <= run_end;
            if (pop_a | pop_b) out_data <= pop_data;
        end
    end

endmodule

// File: tb/tb_merge_node2.sv
// Randomized bench for merge_node2 with queue-based upstream FIFOs and a run-level merge model.
module tb_merge_node2;

    localparam int unsigned DW = 32;
    localparam int unsigned RL = 4;

    typedef struct {
        logic [DW-1:0] data;
        bit            src_b;
        bit            last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] a_dcmp, b_dcmp;
    logic          a_empty, b_empty, a_rd_en, b_rd_en;
    logic          out_full;
    logic [DW-1:0] out_data;
    logic          out_wr_en, out_last;

    merge_node2 #(.DATA_WIDTH(DW), .LOG2_RUN(2)) dut (
        .clk(clk), .reset(reset),
        .a_dcmp(a_dcmp), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_dcmp(b_dcmp), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .out_full(out_full), .out_data(out_data),
        .out_wr_en(out_wr_en), .out_last(out_last)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    logic [DW-1:0] fa[$], fb[$], sa[$], sb[$];
    int            n_chk = 0, n_fail = 0;
    int            out_cnt = 0;
    bit            feed_a_en = 1, feed_b_en = 1, feed_rand = 0;
    int            full_mode = 0;
    int            pa = 0, pb = 0;
    bit            pend_v = 0, pend_src_b = 0;
    bit            do_pop_a = 0, do_pop_b = 0;
    logic [DW-1:0] last_data = '0;
    exp_t          e;
    bit            ep, esb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Model: a run is the stable merge of four A words and four B words.
    task automatic sched(input logic [DW-1:0] ra[$], input logic [DW-1:0] rb[$]);
        int i = 0, j = 0;
        exp_t x;
        for (int k = 0; k < 2 * RL; k++) begin
            if (j >= RL || (i < RL && ra[i] <= rb[j])) begin
                x.data = ra[i]; x.src_b = 0; i++;
            end else begin
                x.data = rb[j]; x.src_b = 1; j++;
            end
            x.last = (k == 2 * RL - 1);
            exp_q.push_back(x);
        end
        foreach (ra[k]) sa.push_back(ra[k]);
        foreach (rb[k]) sb.push_back(rb[k]);
    endtask

    task automatic drive();
        a_empty = (fa.size() == 0);
        b_empty = (fb.size() == 0);
        if (a_empty) a_dcmp = $urandom; else a_dcmp = fa[0];
        if (b_empty) b_dcmp = $urandom; else b_dcmp = fb[0];
        out_full = (full_mode == 2) ? 1'b1 :
                   (full_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (do_pop_a) void'(fa.pop_front());
        if (do_pop_b) void'(fb.pop_front());
        do_pop_a = 0;
        do_pop_b = 0;
        while (feed_a_en && sa.size() > 0) begin
            if (feed_rand && $urandom_range(0, 2) == 0) break;
            fa.push_back(sa.pop_front());
            if (feed_rand) break;
        end
        while (feed_b_en && sb.size() > 0) begin
            if (feed_rand && $urandom_range(0, 2) == 0) break;
            fb.push_back(sb.pop_front());
            if (feed_rand) break;
        end
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || pend_v) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 64'(n >= budget), 64'(0));
    endtask

    // Compare process: registered outputs vs model, and pop decision vs merge rules.
    always @(negedge clk) begin
        if (reset) begin
            pend_v = 0; do_pop_a = 0; do_pop_b = 0;
            pa = 0; pb = 0; last_data = '0;
        end else begin
            check("wr_en", 64'(out_wr_en), 64'(pend_v));
            if (pend_v) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("exp_underflow", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("data", 64'(out_data), 64'(e.data));
                    check("last", 64'(out_last), 64'(e.last));
                    check("src", 64'(pend_src_b), 64'(e.src_b));
                    last_data = e.data;
                end
            end else begin
                check("hold", 64'(out_data), 64'(last_data));
                check("last_idle", 64'(out_last), 64'(0));
            end

            if (pa < RL && pb < RL) begin
                ep  = fa.size() > 0 && fb.size() > 0 && !out_full;
                esb = ep && !(fa[0] <= fb[0]);
            end else if (pa == RL) begin
                ep = fb.size() > 0 && !out_full; esb = 1;
            end else begin
                ep = fa.size() > 0 && !out_full; esb = 0;
            end
            check("rd_a", 64'(a_rd_en), 64'(ep && !esb));
            check("rd_b", 64'(b_rd_en), 64'(ep && esb));
            if ((a_rd_en && fa.size() == 0) || (b_rd_en && fb.size() == 0))
                check("rd_on_empty", 64'(1), 64'(0));

            do_pop_a   = a_rd_en && fa.size() > 0;
            do_pop_b   = b_rd_en && !a_rd_en && fb.size() > 0;
            pend_v     = do_pop_a || do_pop_b;
            pend_src_b = do_pop_b;
            if (do_pop_a) pa++;
            if (do_pop_b) pb++;
            if (pa == RL && pb == RL) begin pa = 0; pb = 0; end
        end
    end

    initial begin
        logic [DW-1:0] ra[$], rb[$];
        int base, n;

        reset = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_wr", 64'(out_wr_en), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        #2 reset = 1'b0;

        // 1: interleaved runs
        base = exp_q.size();
        ra = '{1, 3, 5, 7}; rb = '{2, 4, 6, 8};
        sched(ra, rb);
        for (int i = 0; i < 8; i++) check("pin1_data", 64'(exp_q[base + i].data), 64'(i + 1));
        check("pin1_last", 64'(exp_q[base + 7].last), 64'(1));
        drain(100);

        // 2: A entirely below B
        base = exp_q.size();
        ra = '{1, 2, 3, 4}; rb = '{9, 9, 9, 9};
        sched(ra, rb);
        check("pin2_w3", 64'(exp_q[base + 3].data), 64'(4));
        check("pin2_w4", 64'(exp_q[base + 4].data), 64'(9));
        drain(100);

        // 3: all ties resolve to A first
        base = exp_q.size();
        ra = '{5, 5, 5, 5}; rb = '{5, 5, 5, 5};
        sched(ra, rb);
        for (int i = 0; i < 8; i++) check("pin3_src", 64'(exp_q[base + i].src_b), 64'(i >= 4));
        drain(100);

        // 4: B starved for 6 cycles
        feed_b_en = 0;
        ra = '{1, 3, 10, 11}; rb = '{2, 4, 12, 13};
        sched(ra, rb);
        repeat (6) begin
            cycle();
            check("starve_rd_a", 64'(a_rd_en), 64'(0));
        end
        feed_b_en = 1;
        drain(100);

        // 5: out_full held 3 cycles mid-run, followed by back-to-back runs
        ra = '{0, 7, 8, 20}; rb = '{1, 2, 30, 31};
        sched(ra, rb);
        ra = '{3, 4, 5, 6}; rb = '{3, 3, 9, 100};
        sched(ra, rb);
        repeat (3) cycle();
        full_mode = 2;
        repeat (3) cycle();
        full_mode = 0;
        drain(100);

        // 6: async reset after 3 outputs
        ra = '{2, 4, 6, 8}; rb = '{1, 3, 5, 7};
        sched(ra, rb);
        out_cnt = 0; n = 0;
        while (out_cnt < 3 && n < 50) begin cycle(); n++; end
        check("rst_wait_timeout", 64'(n >= 50), 64'(0));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_data", 64'(out_data), 64'(0));
        check("midrst_wr", 64'(out_wr_en), 64'(0));
        check("midrst_last", 64'(out_last), 64'(0));
        fa.delete(); fb.delete(); sa.delete(); sb.delete(); exp_q.delete();
        do_pop_a = 0; do_pop_b = 0;
        drive();
        @(posedge clk);
        #3 reset = 1'b0;
        ra = '{10, 20, 30, 40}; rb = '{15, 25, 35, 45};
        sched(ra, rb);
        drain(100);

        // Randomized runs, random feed and backpressure
        feed_rand = 1;
        full_mode = 1;
        for (int r = 0; r < 30; r++) begin
            ra.delete(); rb.delete();
            for (int k = 0; k < RL; k++) begin
                ra.push_back((r % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 15)));
                rb.push_back((r % 3 == 0) ? DW'($urandom) : DW'($urandom_range(0, 15)));
            end
            ra.sort(); rb.sort();
            sched(ra, rb);
            if ($urandom_range(0, 1) == 0) drain(400);
        end
        drain(2000);
        check("fifo_a_empty", 64'(fa.size() + sa.size()), 64'(0));
        check("fifo_b_empty", 64'(fb.size() + sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
